// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core: default address width and the
// loop-stack operation encoding used by both the decoder and the loop stack.
package bf_pkg;

  localparam int BF_ADDR_W = 10;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    PUSH    = 3'd1,
    POP     = 3'd2,
    REPLACE = 3'd3,
    FLUSH   = 3'd4
  } stack_op_e;

  // Collapse the raw strobes into one operation; flush dominates push/pop,
  // and push with pop together means "replace the top entry".
  function automatic stack_op_e decode_op(input logic flush,
                                          input logic push,
                                          input logic pop);
    stack_op_e op;
    op = NONE;
    if (flush)            op = FLUSH;
    else if (push && pop) op = REPLACE;
    else if (push)        op = PUSH;
    else if (pop)         op = POP;
    return op;
  endfunction

endpackage

// File: rtl/bf_stack_ram.sv
// Storage array for the loop stack: DEPTH x ADDR_W, one synchronous write
// port and one asynchronous read port. Contents are never reset.
module bf_stack_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 10,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bf_loop_stack.sv
// Return-address stack for the loop unit. '[' pushes the loop-body PC,
// ']' peeks the top to jump back and pops on loop exit. Provides occupancy
// status, sticky overflow/underflow flags and a flush for program restart.
// Optional build macro LOOP_STACK_HWM_EN adds a max_depth high-water mark
// output that only rst clears.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_W,
  parameter int DEPTH  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] address_in,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
`ifdef LOOP_STACK_HWM_EN
  ,
  output logic [CNT_W-1:0]  max_depth
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  stack_op_e         op;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] rd_data;

  assign op      = decode_op(flush, push, pop);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // Index of the top entry; parked at 0 when empty so the read stays in range.
  assign top_idx = empty ? '0 : IDX_W'(count_q - CNT_W'(1));

  // Next count, error flags and write request from the decoded operation;
  // the empty/full guards keep count inside 0..DEPTH without wrapping.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = IDX_W'(count_q);
    unique case (op)
      FLUSH: begin
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      PUSH: begin
        if (!full) begin
          we      = 1'b1;
          waddr   = IDX_W'(count_q);
          count_d = count_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      POP: begin
        if (!empty) count_d = count_q - CNT_W'(1);
        else        unf_d   = 1'b1;
      end
      REPLACE: begin
        if (!empty) begin
          we    = 1'b1;
          waddr = top_idx;
        end else begin
          unf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and sticky flags; rst overrides everything on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  bf_stack_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we && !rst),
    .waddr (waddr),
    .wdata (address_in),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  assign top       = empty ? '0 : rd_data;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef LOOP_STACK_HWM_EN
  logic [CNT_W-1:0] hwm_q;

  // High-water mark of the post-edge count; survives flush, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end
  end

  assign max_depth = hwm_q;
`else
  // High-water mark tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_bf_loop_stack.sv
// Bench for bf_loop_stack: a driver issues one operation per cycle and pushes
// the expected post-edge state from a queue-based stack model; a monitor pops
// and compares after every rising edge.
module tb_bf_loop_stack;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;
    logic [CNT_W-1:0]  hwm;
  } exp_t;

  localparam int W = $bits(exp_t);

  // Clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] address_in = '0;
  logic [ADDR_W-1:0] top;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  max_depth_w;

  always #5 clk = ~clk;

  bf_loop_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .address_in (address_in),
    .top        (top),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef LOOP_STACK_HWM_EN
    ,
    .max_depth  (max_depth_w)
`endif
  );

`ifndef LOOP_STACK_HWM_EN
  assign max_depth_w = '0;
`endif

  // Reference model: the stack as a plain queue
  logic [ADDR_W-1:0] m_stk[$];
  bit                m_ovf;
  bit                m_unf;
  int                m_hwm;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
  endtask

  // Driver: one operation per cycle, expected state queued before the edge
  task automatic step(input logic r, input logic pu, input logic po,
                      input logic fl, input logic [ADDR_W-1:0] a);
    exp_t e;
    int   sz;
    @(negedge clk);
    rst = r; push = pu; pop = po; flush = fl; address_in = a;
    if (r) begin
      m_stk.delete(); m_ovf = 0; m_unf = 0; m_hwm = 0;
    end else if (fl) begin
      m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (pu && po) begin
      if (m_stk.size() > 0) m_stk[m_stk.size()-1] = a;
      else m_unf = 1;
    end else if (pu) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(a);
      else m_ovf = 1;
    end else if (po) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_unf = 1;
    end
    sz = m_stk.size();
    if (sz > m_hwm) m_hwm = sz;
    e.top   = (sz > 0) ? m_stk[sz-1] : '0;
    e.count = CNT_W'(sz);
    e.empty = (sz == 0);
    e.full  = (sz == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.hwm   = CNT_W'(m_hwm);
    exp_q.push_back(e);
  endtask

  task automatic do_push(input logic [ADDR_W-1:0] a); step(0, 1, 0, 0, a); endtask
  task automatic do_pop();                            step(0, 0, 1, 0, '0); endtask
  task automatic idle();                              step(0, 0, 0, 0, '0); endtask

  // Monitor: compare the registered outputs just after each rising edge
  always @(posedge clk) begin
    exp_t ev;
    #1;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      chk("top",       int'(top),       int'(ev.top));
      chk("count",     int'(count),     int'(ev.count));
      chk("empty",     int'(empty),     int'(ev.empty));
      chk("full",      int'(full),      int'(ev.full));
      chk("overflow",  int'(overflow),  int'(ev.ovf));
      chk("underflow", int'(underflow), int'(ev.unf));
`ifdef LOOP_STACK_HWM_EN
      chk("max_depth", int'(max_depth_w), int'(ev.hwm));
`endif
    end
  end

  // Stimulus
  initial begin
    int pw;
    int r;
    logic [ADDR_W-1:0] a;

    // Reset, then three pushes and pops down past empty
    step(1, 0, 0, 0, '0);
    do_push(10'h010); do_push(10'h020); do_push(10'h030);
    do_pop(); do_pop(); do_pop(); do_pop();

    // Fill to full, overflow attempt, drain in LIFO order
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) do_push(ADDR_W'(i * 13 + 5));
    do_push(10'h3FF);
    for (int i = 0; i < DEPTH; i++) do_pop();

    // Replace the top entry at count=2
    step(1, 0, 0, 0, '0);
    do_push(10'h011); do_push(10'h040);
    step(0, 1, 1, 0, 10'h055);
    do_pop();
    step(0, 1, 1, 0, 10'h066);  // replace on a one-entry stack
    do_pop();
    step(0, 1, 1, 0, 10'h077);  // replace while empty -> underflow

    // Overflow with count=5, then flush with push, then rst with push
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) do_push(ADDR_W'(i + 100));
    do_push(10'h123);
    for (int i = 0; i < DEPTH - 5; i++) do_pop();
    step(0, 1, 0, 1, 10'h2AA);
    idle();
    do_push(10'h0AB); do_push(10'h0CD);
    step(1, 1, 0, 0, 10'h1EE);
    idle();

    // High-water profile across a flush
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 7; i++) do_push(ADDR_W'(i + 1));
    for (int i = 0; i < 4; i++) do_pop();
    step(0, 0, 0, 1, '0);
    do_push(10'h001); do_push(10'h002);
    step(1, 0, 0, 0, '0);

    // Randomized phases alternating push-heavy and pop-heavy traffic
    for (int i = 0; i < 800; i++) begin
      pw = ((i / 80) % 2 == 0) ? 72 : 28;
      r  = $urandom_range(0, 199);
      a  = ADDR_W'($urandom);
      if (r == 0)
        step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), a);
      else if (r < 4)
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, a);
      else
        step(0, ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < (100 - pw)), 0, a);
    end
    idle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bf_loop_stack.md
Name: bf_loop_stack

Overview:
Clocked, parametrised return-address stack for the brainfuck core's loop unit.
- '[' pushes the program-counter address of the loop body; ']' reads the top address to jump back, and pops when the loop exits.
- Unlike the first-generation stack, it is fully synchronous and exposes a top-of-stack peek. It also provides full/empty/count status, sticky overflow/underflow error flags, and a flush.
- Sits between the instruction decoder and the PC mux.

Parameters:
ADDR_W, 10, width of stored instruction addresses
DEPTH, 32, number of stack entries (>=2, any integer, not restricted to power of two)
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
push  input  1  push address_in this cycle
pop  input  1  pop top entry this cycle
flush  input  1  discard all entries (program restart)
address_in  input  ADDR_W  address to push
top  output  ADDR_W  current top-of-stack address (peek)
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  CNT_W  number of valid entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - count=0, empty=1, full=0, overflow=0, underflow=0, top=0.
  - Memory contents are not reset.
- top, empty, full and count are functions of registered state only.
  - top = mem[count-1] when count>0, else 0.
  - Valid in the cycle after the edge that changed the state (zero-cycle peek, one-cycle update latency).
- Priority per edge: rst > flush > push/pop.
- flush:
  - Sets count=0.
  - Clears overflow and underflow.
  - Ignores push/pop that cycle.
- push only:
  - If !full: mem[count] <= address_in, count+1.
  - If full: no write, count unchanged, overflow <= 1.
- pop only:
  - If !empty: count-1. top shows the new top next cycle.
  - If empty: no change, underflow <= 1.
- push and pop together (replace top, used for loop re-entry bookkeeping):
  - If !empty: mem[count-1] <= address_in, count unchanged.
  - If empty: no write, count stays 0, underflow <= 1.
  - Overflow is never raised by a simultaneous push and pop.
- Neither push nor pop: hold.
- No pointer wrap-around. count saturates logically at 0 and DEPTH via the guards above; the arithmetic is CNT_W wide with no modulo behaviour.
- Error flags are sticky until rst or flush; a legal operation does not clear them.
- rst asserted mid-operation wins over any same-cycle push/pop/flush. The next cycle shows reset values.

Optional Feature:
Macro LOOP_STACK_HWM_EN.
- Defined:
  - Adds output max_depth [CNT_W-1:0], a high-water mark of count.
  - Updated each edge to max(max_depth, next count).
  - Cleared by rst only, not by flush, so it profiles nesting across restarts.
- Undefined:
  - Port and register are absent.
  - Other behaviour is identical.

Decomposition:
- Shared package bf_pkg:
  - BF_ADDR_W = 10 constant.
  - Op-code enum type stack_op_e with values NONE, PUSH, POP, REPLACE, FLUSH. The decoder and this block share it.
- One natural sub-module, bf_stack_ram: DEPTH x ADDR_W, single write port, async read port.
- Control, count and flags live in bf_loop_stack.

Test Plan:
- Reset, then push 0x010, 0x020, 0x030 -> count=3, top=0x030, empty=0, no errors.
- From the previous state, pop twice -> top=0x010, count=1. Pop again -> empty=1, top=0. Pop once more -> underflow=1, count stays 0.
- DEPTH=32: push 32 distinct values -> full=1. Push 0x3FF -> overflow=1, top still the 32nd value. Then pop 32 times -> the values return in LIFO order.
- count=2 with top=0x040: assert push and pop together with address_in=0x055 -> count=2, top=0x055. Pop -> top is the original bottom entry.
- With overflow=1 and count=5: flush with push asserted -> count=0, overflow=0, no write. Then rst asserted together with push -> all reset values next cycle.
- LOOP_STACK_HWM_EN: push 7, pop 4, flush, push 2 -> max_depth=7. Then rst -> max_depth=0.
